// File: rtl/apb2ahb_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module      : apb2ahb_pkg                                            |
// | Description : Shared AHB-Lite encodings and bridge FSM state type    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package apb2ahb_pkg;

  // AHB-Lite transfer type encodings (bridge only ever issues these two)
  localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;

  // Every transfer is a single 32-bit word
  localparam logic [2:0] c_HSIZE_WORD    = 3'b010;
  localparam logic [2:0] c_HBURST_SINGLE = 3'b000;

  // Bridge sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage : apb2ahb_pkg
`default_nettype wire

// File: rtl/apb2ahb_if.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module      : apb2ahb_if                                             |
// | Description : APB3 slave + AHB-Lite master signal bundle             |
// |               slave  : view of the bridge itself                     |
// |               master : view of the environment driving the bridge    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface apb2ahb_if;

  // APB3 side
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  // AHB-Lite side
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    output HRDATA, HREADY, HRESP
  );

endinterface : apb2ahb_if
`default_nettype wire

// File: rtl/apb2ahb.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module      : apb2ahb                                                |
// | Description : APB3 slave to AHB-Lite master bridge. One single-word  |
// |               AHB transfer per APB access, never pipelined.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module apb2ahb
  import apb2ahb_pkg::*;
#(
  parameter logic [31:0] AHB_BASE  = 32'h0000_0000,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  wire logic  HCLK,
  input  wire logic  HRESET,
  apb2ahb_if.slave   bus
);

  state_t      r_state;
  logic [31:0] r_pwdata;   // write data held from the APB setup cycle
  logic [31:0] r_haddr;
  logic [1:0]  r_htrans;
  logic        r_hwrite;
  logic [31:0] r_hwdata;
  logic [31:0] r_prdata;
  logic        r_pready;
  logic        r_pslverr;  // doubles as the error flag presented in DONE

  logic        w_setup;
  logic        w_aligned;

  assign w_setup   = bus.PSEL && !bus.PENABLE;
  assign w_aligned = (bus.PADDR[1:0] == 2'b00);

  // Sequencer: all bus outputs are registered alongside the state
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state   <= ST_IDLE;
      r_pwdata  <= '0;
      r_haddr   <= '0;
      r_htrans  <= c_HTRANS_IDLE;
      r_hwrite  <= 1'b0;
      r_hwdata  <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_setup) begin
            r_pwdata <= bus.PWDATA;
            if (w_aligned) begin
              r_haddr  <= AHB_BASE + bus.PADDR;  // wraps modulo 2^32
              r_hwrite <= bus.PWRITE;
              r_htrans <= c_HTRANS_NONSEQ;
              r_state  <= ST_ADDR;
            end else begin
              // Misaligned: answer with an error, never touch the AHB bus
              r_prdata  <= '0;
              r_pready  <= 1'b1;
              r_pslverr <= 1'b1;
              r_state   <= ST_DONE;
            end
          end
        end

        ST_ADDR: begin
          if (bus.HREADY) begin
            r_htrans <= c_HTRANS_IDLE;
            r_hwdata <= r_pwdata;
            r_state  <= ST_DATA;
          end
        end

        ST_DATA: begin
          // HRESP during a stalled cycle is only the first ERROR cycle;
          // the response is taken when HREADY completes the data phase
          if (bus.HREADY) begin
            r_prdata  <= r_hwrite ? 32'h0 : bus.HRDATA;
            r_pslverr <= bus.HRESP;
            r_pready  <= 1'b1;
            r_state   <= ST_DONE;
          end
        end

        ST_DONE: begin
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_state   <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.PRDATA    = r_prdata;
  assign bus.PREADY    = r_pready;
  assign bus.PSLVERR   = r_pslverr;
  assign bus.HADDR     = r_haddr;
  assign bus.HTRANS    = r_htrans;
  assign bus.HWRITE    = r_hwrite;
  assign bus.HWDATA    = r_hwdata;
  assign bus.HSIZE     = c_HSIZE_WORD;
  assign bus.HBURST    = c_HBURST_SINGLE;
  assign bus.HPROT     = HPROT_VAL;
  assign bus.HMASTLOCK = 1'b0;

endmodule : apb2ahb
`default_nettype wire
